led_pattern_scheduler: RTL

Playlist controller that sequences the multi-pattern LED sequencer by driving its pattern_sel and clk_selector inputs. Holds an 8-entry table of {pattern, speed, dwell} and plays entries 0..cfg_len in order, showing each for a programmable number of time-base ticks. Sits between the ui_in control switches / config port and the sequencer core, in the clk_10MHz domain.

---
 rtl/led_pattern_scheduler.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/led_pattern_scheduler.sv
// Playlist controller stepping the LED sequencer through an 8-entry {dwell,speed,pattern} table.
// Define PINGPONG_EN to bounce between entry 0 and cfg_len instead of wrapping.
module led_pattern_scheduler #(
    parameter int TICK_DIV = 1000000,
    parameter int ENTRIES  = 8
) (
    input  logic       clk_10MHz,
    input  logic       rstn,
    input  logic       start,
    input  logic       stop,
    input  logic       step,
    input  logic       cfg_we,
    input  logic [2:0] cfg_addr,
    input  logic [9:0] cfg_data,
    input  logic [2:0] cfg_len,
    output logic [3:0] pattern_sel,
    output logic [1:0] clk_selector,
    output logic [2:0] entry_idx,
    output logic       busy,
    output logic       pattern_changed
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_PLAY
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [9:0]    r_tab [ENTRIES];
    logic [2:0]    r_idx;
    logic [3:0]    r_pat;
    logic [1:0]    r_spd;
    logic [2:0]    r_eidx;
    logic          r_pc;
    logic [PW-1:0] r_presc;
    logic [3:0]    r_cnt;
    logic [9:0]    w_ent;
    logic          w_tick;
    logic          w_adv;
    logic [2:0]    w_idx_adv;
`ifdef PINGPONG_EN
    logic          r_up;
    logic          w_up_nxt;
`endif

    assign w_ent  = r_tab[r_idx];
    assign w_tick = (r_presc == PW'(TICK_DIV - 1));

`ifdef PINGPONG_EN
    always_comb begin
        w_up_nxt  = r_up;
        w_idx_adv = r_idx;
        if (r_up) begin
            if (r_idx >= cfg_len) begin
                w_up_nxt  = 1'b0;
                w_idx_adv = (cfg_len == 3'd0) ? 3'd0 : cfg_len - 3'd1;
            end else begin
                w_idx_adv = r_idx + 3'd1;
            end
        end else begin
            if (r_idx == 3'd0) begin
                w_up_nxt  = 1'b1;
                w_idx_adv = (cfg_len == 3'd0) ? 3'd0 : 3'd1;
            end else begin
                w_idx_adv = r_idx - 3'd1;
            end
        end
    end
`else
    assign w_idx_adv = (r_idx >= cfg_len) ? 3'd0 : r_idx + 3'd1;
`endif

    // stop outranks step, step outranks the dwell tick
    always_comb begin
        w_state_nxt = r_state;
        w_adv       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start && !stop) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                w_state_nxt = stop ? S_IDLE : S_PLAY;
            end
            S_PLAY: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                end else if (step || (w_tick && r_cnt == 4'd1)) begin
                    w_adv       = 1'b1;
                    w_state_nxt = S_LOAD;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_10MHz or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < ENTRIES; i++)
                r_tab[i] <= {4'd1, 2'd0, 4'(i)};
        end else if (cfg_we) begin
            r_tab[cfg_addr] <= cfg_data;
        end
    end

    always_ff @(posedge clk_10MHz or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_idx   <= 3'd0;
            r_pat   <= 4'd0;
            r_spd   <= 2'd0;
            r_eidx  <= 3'd0;
            r_pc    <= 1'b0;
            r_presc <= '0;
            r_cnt   <= 4'd0;
`ifdef PINGPONG_EN
            r_up    <= 1'b1;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= 1'b0;
            if (r_state == S_IDLE && w_state_nxt == S_LOAD) begin
                r_idx <= 3'd0;
`ifdef PINGPONG_EN
                r_up  <= 1'b1;
`endif
            end
            if (r_state == S_LOAD && !stop) begin
                r_pat   <= w_ent[3:0];
                r_spd   <= w_ent[5:4];
                r_eidx  <= r_idx;
                r_cnt   <= w_ent[9:6];
                r_presc <= '0;
                r_pc    <= 1'b1;
            end
            // a zero dwell never reaches 1, so the entry is held until step/stop
            if (r_state == S_PLAY) begin
                r_presc <= w_tick ? '0 : r_presc + PW'(1);
                if (w_tick && r_cnt > 4'd1)
                    r_cnt <= r_cnt - 4'd1;
            end
            if (w_adv) begin
                r_idx <= w_idx_adv;
`ifdef PINGPONG_EN
                r_up  <= w_up_nxt;
`endif
            end
        end
    end

    assign pattern_sel     = r_pat;
    assign clk_selector    = r_spd;
    assign entry_idx       = r_eidx;
    assign busy            = (r_state != S_IDLE);
    assign pattern_changed = r_pc;

endmodule
